// File: rtl/maxt_pkg.sv
// Shared definitions for the max/min-of-T histogram block.
// Holds the mode encoding and the default parameter values, so the top
// level and the lane reducer agree on them.
`timescale 1ns/1ps
package maxt_pkg;

  // Reduction direction: max (0) or min (1).
  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  localparam int W_DEF        = 32;
  localparam int LANES_DEF    = 4;
  localparam int T_DEF        = 16;
  localparam int BIN_BITS_DEF = 5;
  localparam int CNT_W_DEF    = 64;

endpackage

// File: rtl/maxt_reduce.sv
// Combinational LANES-input unsigned max/min reducer.
// Ports:
//   mode    : MODE_MAX selects the largest lane, MODE_MIN the smallest
//   in_data : LANES packed samples, lane i at in_data[i*W +: W]
//   red_out : selected sample
`timescale 1ns/1ps
module maxt_reduce
  import maxt_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic               mode,
  input  logic [LANES*W-1:0] in_data,
  output logic [W-1:0]       red_out
);

  logic [W-1:0] lane;

  // Ties keep the incumbent; either choice yields the same value.
  always_comb begin
    red_out = in_data[W-1:0];
    lane    = '0;
    for (int i = 1; i < LANES; i++) begin
      lane = in_data[i*W +: W];
      if ((mode == MODE_MIN) ? (lane < red_out) : (lane > red_out)) begin
        red_out = lane;
      end
    end
  end

endmodule

// File: rtl/maxt_hist.sv
// Max/min-of-T histogram.
// Each accepted beat of LANES samples is reduced to its max (mode 0) or
// min (mode 1); T/LANES beats form a group whose reduced result selects a
// histogram bin via its top BIN_BITS bits. Bin counters and the group
// total saturate; sat is sticky until clear or rst.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   clear              : synchronous flush of pipeline and histogram
//   mode               : 0 = max-of-T, 1 = min-of-T (latched per group)
//   in_valid/in_ready  : beat handshake, in_ready = !clear
//   in_data            : LANES x W samples
//   rd_en/rd_addr      : bin read request
//   rd_data/rd_valid   : registered bin count, one cycle after rd_en
//   total              : completed groups
//   sat                : a counter has saturated
`timescale 1ns/1ps
module maxt_hist
  import maxt_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int T        = T_DEF,
  parameter int BIN_BITS = BIN_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*W-1:0]  in_data,
  input  logic                rd_en,
  input  logic [BIN_BITS-1:0] rd_addr,
  output logic [CNT_W-1:0]    rd_data,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    total,
  output logic                sat
);

  localparam int NB    = 1 << BIN_BITS;
  localparam int BEATS = T / LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  if ((LANES < 1) || (LANES > 16) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
    $error("maxt_hist: LANES must be a power of 2 in 1..16");
  end
  if ((T < 1) || ((T & (T - 1)) != 0) || ((T % LANES) != 0)) begin : g_bad_t
    $error("maxt_hist: T must be a power of 2 and a multiple of LANES");
  end
  if ((BIN_BITS < 1) || (BIN_BITS > W)) begin : g_bad_bins
    $error("maxt_hist: BIN_BITS must be in 1..W");
  end

  function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic m);
    if (m == MODE_MIN) return (b < a) ? b : a;
    return (b > a) ? b : a;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Input-side group tracking
  logic [BCW-1:0]      beat_q, beat_d;
  logic                mode_lat_q, mode_lat_d;
  // Stage A
  logic [W-1:0]        a_p0_q, a_p0_d;
  logic                vld_p0_q, vld_p0_d;
  logic                first_p0_q, first_p0_d;
  logic                last_p0_q, last_p0_d;
  logic                mode_p0_q, mode_p0_d;
  // Stage B
  logic [W-1:0]        acc_p1_q, acc_p1_d;
  logic [BIN_BITS-1:0] grp_bin_p1_q, grp_bin_p1_d;
  logic                vld_p1_q, vld_p1_d;
  // Stage C
  logic [CNT_W-1:0]    bins_q [NB];
  logic [CNT_W-1:0]    bins_d [NB];
  logic [CNT_W-1:0]    total_q, total_d;
  logic                sat_q, sat_d;
  // Read port
  logic [CNT_W-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic                accept, first_beat, last_beat, mode_eff;
  logic [W-1:0]        red_out, fold;
  logic [CNT_W-1:0]    bin_inc, total_inc;

  assign in_ready   = !clear;
  assign accept     = in_valid && !clear;
  assign first_beat = (beat_q == '0);
  assign last_beat  = (beat_q == LAST_BEAT);
  // The first beat of a group uses the live mode; the rest use the latch.
  assign mode_eff   = first_beat ? mode : mode_lat_q;

  maxt_reduce #(.W(W), .LANES(LANES)) u_reduce (
    .mode    (mode_eff),
    .in_data (in_data),
    .red_out (red_out)
  );

  always_comb begin
    beat_d       = beat_q;
    mode_lat_d   = mode_lat_q;
    a_p0_d       = a_p0_q;
    vld_p0_d     = accept;
    first_p0_d   = first_p0_q;
    last_p0_d    = last_p0_q;
    mode_p0_d    = mode_p0_q;
    acc_p1_d     = acc_p1_q;
    grp_bin_p1_d = grp_bin_p1_q;
    vld_p1_d     = vld_p0_q && last_p0_q;
    bins_d       = bins_q;
    total_d      = total_q;
    sat_d        = sat_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_en;
    fold         = '0;
    bin_inc      = '0;
    total_inc    = '0;

    // Stage A: per-beat reduction
    if (accept) begin
      beat_d     = last_beat ? '0 : beat_q + BCW'(1);
      if (first_beat) mode_lat_d = mode;
      a_p0_d     = red_out;
      first_p0_d = first_beat;
      last_p0_d  = last_beat;
      mode_p0_d  = mode_eff;
    end

    // Stage B: group accumulation; a first beat reloads, so no bubble
    if (vld_p0_q) begin
      fold     = first_p0_q ? a_p0_q : pick(acc_p1_q, a_p0_q, mode_p0_q);
      acc_p1_d = fold;
      if (last_p0_q) grp_bin_p1_d = fold[W-1 -: BIN_BITS];
    end

    // Stage C: histogram update
    if (vld_p1_q) begin
      bin_inc              = sat_inc(bins_q[grp_bin_p1_q]);
      total_inc            = sat_inc(total_q);
      bins_d[grp_bin_p1_q] = bin_inc;
      total_d              = total_inc;
      sat_d                = sat_q | (&bin_inc) | (&total_inc);
    end

    // Read sees the pre-update array
    if (rd_en) rd_data_d = bins_q[rd_addr];

    if (clear) begin
      beat_d     = '0;
      a_p0_d     = '0;
      vld_p0_d   = 1'b0;
      acc_p1_d   = '0;
      vld_p1_d   = 1'b0;
      for (int i = 0; i < NB; i++) bins_d[i] = '0;
      total_d    = '0;
      sat_d      = 1'b0;
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q       <= '0;
      mode_lat_q   <= 1'b0;
      a_p0_q       <= '0;
      vld_p0_q     <= 1'b0;
      first_p0_q   <= 1'b0;
      last_p0_q    <= 1'b0;
      mode_p0_q    <= 1'b0;
      acc_p1_q     <= '0;
      grp_bin_p1_q <= '0;
      vld_p1_q     <= 1'b0;
      for (int i = 0; i < NB; i++) bins_q[i] <= '0;
      total_q      <= '0;
      sat_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      beat_q       <= beat_d;
      mode_lat_q   <= mode_lat_d;
      a_p0_q       <= a_p0_d;
      vld_p0_q     <= vld_p0_d;
      first_p0_q   <= first_p0_d;
      last_p0_q    <= last_p0_d;
      mode_p0_q    <= mode_p0_d;
      acc_p1_q     <= acc_p1_d;
      grp_bin_p1_q <= grp_bin_p1_d;
      vld_p1_q     <= vld_p1_d;
      bins_q       <= bins_d;
      total_q      <= total_d;
      sat_q        <= sat_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign total    = total_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_maxt_hist.sv
`timescale 1ns/1ps
module tb_maxt_hist;
  localparam int W = 32, LANES = 4, BB = 5, CW = 64;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, mode = 1'b0;
  logic in_valid = 1'b0, in_valid_s = 1'b0, rd_en = 1'b0;
  logic [LANES*W-1:0] in_data = '0;
  logic [BB-1:0] rd_addr = '0;
  logic in_ready, rd_valid, sat, in_ready_s, rd_valid_s, sat_s;
  logic [CW-1:0] rd_data, total;
  logic [3:0] rd_data_s, total_s;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  maxt_hist dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .total(total), .sat(sat)
  );

  maxt_hist #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .in_valid(in_valid_s),
    .in_ready(in_ready_s), .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s), .total(total_s), .sat(sat_s)
  );

  function automatic logic [127:0] mk(input logic [31:0] l3, input logic [31:0] l2,
                                      input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic put(input logic [127:0] d, input logic m, input bit to_s);
    @(negedge clk);
    in_data    = d;
    mode       = m;
    in_valid   = !to_s;
    in_valid_s = to_s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid   = 1'b0;
      in_valid_s = 1'b0;
    end
  endtask

  task automatic rd(input int a, output logic [63:0] d, output logic v, output logic [3:0] ds);
    @(negedge clk);
    in_valid = 1'b0; in_valid_s = 1'b0;
    rd_en = 1'b1; rd_addr = 5'(a);
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data; v = rd_valid; ds = rd_data_s;
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0; in_valid_s = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d; logic v; logic [3:0] ds;
    #1;
    checks++; if (total !== 64'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", total); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd: got v=%b d=%0d want 0/0", rd_valid, rd_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd(0, d, v, ds);
    checks++; if (v !== 1'b1 || d !== 64'd0) begin errors++; $display("FAIL reset_bin0: got v=%b d=%0d want 1/0", v, d); end
  endtask

  task automatic test_max();
    logic [63:0] d; logic v; logic [3:0] ds;
    put(mk(0, 0, 0, 0), 1'b0, 0);
    put(mk(0, 0, 0, 0), 1'b0, 0);
    put(mk(0, 32'hF800_0000, 0, 0), 1'b0, 0);
    put(mk(0, 0, 0, 0), 1'b0, 0);
    idle(2);
    checks++; if (total !== 64'd0) begin errors++; $display("FAIL max_latency_early: got total=%0d want 0", total); end
    idle(1);
    checks++; if (total !== 64'd1) begin errors++; $display("FAIL max_total: got %0d want 1", total); end
    rd(31, d, v, ds);
    checks++; if (v !== 1'b1 || d !== 64'd1) begin errors++; $display("FAIL max_bin31: got v=%b d=%0d want 1/1", v, d); end
    rd(0, d, v, ds);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL max_bin0: got %0d want 0", d); end
  endtask

  task automatic test_min();
    logic [63:0] d; logic v; logic [3:0] ds;
    do_clear();
    put(mk(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 1'b1, 0);
    put(mk(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 1'b1, 0);
    put(mk(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 1'b1, 0);
    put(mk(32'h1000_0000, 32'h0800_0001, 32'h1000_0000, 32'h1000_0000), 1'b1, 0);
    idle(4);
    checks++; if (total !== 64'd1) begin errors++; $display("FAIL min_total: got %0d want 1", total); end
    rd(1, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL min_bin1: got %0d want 1", d); end
    rd(2, d, v, ds);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL min_bin2: got %0d want 0", d); end
  endtask

  // Mode flips to min after the first beat: the group still reduces as max.
  task automatic test_mode_latch();
    logic [63:0] d; logic v; logic [3:0] ds;
    do_clear();
    for (int g = 0; g < 2; g++) begin
      put(mk(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), g[0], 0);
      put(mk(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000), 1'b1, 0);
      put(mk(32'h0800_0000, 32'hF800_0000, 32'h0800_0000, 32'h0800_0000), 1'b1, 0);
      put(mk(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000), 1'b1, 0);
    end
    idle(4);
    checks++; if (total !== 64'd2) begin errors++; $display("FAIL latch_total: got %0d want 2", total); end
    rd(31, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL latch_bin31: got %0d want 1", d); end
    rd(1, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL latch_bin1: got %0d want 1", d); end
    rd(2, d, v, ds);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL latch_bin2: got %0d want 0", d); end
  endtask

  // Group 0 max 0x2000_0000 -> bin 4; group 1 max 0x6800_0000 -> bin 13.
  task automatic run_gaps(input bit gaps);
    logic [63:0] d; logic v; logic [3:0] ds;
    logic [127:0] b;
    do_clear();
    for (int k = 0; k < 8; k++) begin
      b = mk(32'(k * 256), 32'(k * 256), 32'(k * 256), 32'(k * 256));
      if (k == 1) b[127:96] = 32'h2000_0000;
      if (k == 7) b[31:0]   = 32'h6800_0000;
      put(b, 1'b0, 0);
      if (gaps) idle((k % 3) + 1);
    end
    idle(4);
    checks++; if (total !== 64'd2) begin errors++; $display("FAIL gaps%0d_total: got %0d want 2", gaps, total); end
    rd(4, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL gaps%0d_bin4: got %0d want 1", gaps, d); end
    rd(13, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL gaps%0d_bin13: got %0d want 1", gaps, d); end
    rd(0, d, v, ds);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL gaps%0d_bin0: got %0d want 0", gaps, d); end
  endtask

  task automatic test_gaps();
    run_gaps(1'b1);
    run_gaps(1'b0);
  endtask

  task automatic test_clear();
    logic [63:0] d; logic v; logic [3:0] ds;
    put(mk(0, 32'hF800_0000, 0, 0), 1'b0, 0);
    put(mk(0, 32'hF800_0000, 0, 0), 1'b0, 0);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = mk(0, 32'hF800_0000, 0, 0);
    rd_en = 1'b1; rd_addr = 5'd4;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0 || rd_data !== 64'd0) begin errors++; $display("FAIL clear_rd: got v=%b d=%0d want 0/0", rd_valid, rd_data); end
    checks++; if (total !== 64'd0) begin errors++; $display("FAIL clear_total: got %0d want 0", total); end
    for (int k = 0; k < 4; k++) put(mk(0, 0, (k == 2) ? 32'd1 : 32'd0, 0), 1'b0, 0);
    idle(4);
    checks++; if (total !== 64'd1) begin errors++; $display("FAIL clear_total_after: got %0d want 1", total); end
    rd(0, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL clear_bin0: got %0d want 1", d); end
    rd(31, d, v, ds);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL clear_bin31: got %0d want 0", d); end
    rd(4, d, v, ds);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL clear_bin4: got %0d want 0", d); end
  endtask

  task automatic test_rst_mid();
    logic [63:0] d; logic v; logic [3:0] ds;
    put(mk(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000), 1'b0, 0);
    put(mk(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000), 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) put(mk(0, 0, 0, (k == 3) ? 32'hF800_0000 : 32'd0), 1'b0, 0);
    for (int k = 0; k < 4; k++) put(mk(0, 0, 0, 0), 1'b0, 0);
    idle(4);
    checks++; if (total !== 64'd2) begin errors++; $display("FAIL rst_total: got %0d want 2", total); end
    rd(31, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL rst_bin31: got %0d want 1", d); end
    rd(0, d, v, ds);
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL rst_bin0: got %0d want 1", d); end
    rd(8, d, v, ds);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL rst_bin8: got %0d want 0", d); end
  endtask

  task automatic test_sat();
    logic [63:0] d; logic v; logic [3:0] ds;
    do_clear();
    for (int g = 0; g < 14; g++) for (int k = 0; k < 4; k++) put(mk(0, 0, 0, 0), 1'b0, 1);
    idle(4);
    checks++; if (total_s !== 4'd14 || sat_s !== 1'b0) begin errors++; $display("FAIL sat_pre: got total=%0d sat=%b want 14/0", total_s, sat_s); end
    for (int g = 0; g < 2; g++) for (int k = 0; k < 4; k++) put(mk(0, 0, 0, 0), 1'b0, 1);
    idle(4);
    checks++; if (total_s !== 4'd15) begin errors++; $display("FAIL sat_total: got %0d want 15", total_s); end
    checks++; if (sat_s !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", sat_s); end
    rd(0, d, v, ds);
    checks++; if (ds !== 4'd15) begin errors++; $display("FAIL sat_bin0: got %0d want 15", ds); end
    checks++; if (total !== 64'd0) begin errors++; $display("FAIL sat_main_untouched: got %0d want 0", total); end
    idle(3);
    checks++; if (sat_s !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", sat_s); end
    do_clear();
    checks++; if (sat_s !== 1'b0 || total_s !== 4'd0) begin errors++; $display("FAIL sat_clear: got sat=%b total=%0d want 0/0", sat_s, total_s); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_min();
    test_mode_latch();
    test_gaps();
    test_clear();
    test_rst_mid();
    test_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/maxt_hist.md
MAXT_HIST -- requirements
Module: maxt_hist

Interface
REQ-001 SHALL have parameter W, default 32, sample width in bits.
REQ-002 SHALL have parameter LANES, default 4, samples per input beat; power of 2, 1..16.
REQ-003 SHALL have parameter T, default 16, samples per group; power of 2 and a multiple of LANES.
REQ-004 SHALL have parameter BIN_BITS, default 5, histogram index width; number of bins NB = 2^BIN_BITS.
REQ-005 SHALL have parameter CNT_W, default 64, width of each bin counter and of total.
REQ-006 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port clear, input, 1, synchronous flush of pipeline and histogram.
REQ-009 SHALL have port mode, input, 1, 0 = max-of-T, 1 = min-of-T.
REQ-010 SHALL have port in_valid, input, 1, beat valid.
REQ-011 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready.
REQ-012 SHALL have port in_data, input, LANES x W, one beat of samples.
REQ-013 SHALL have port rd_en, input, 1, histogram read request.
REQ-014 SHALL have port rd_addr, input, BIN_BITS, bin to read.
REQ-015 SHALL have port rd_data, output, CNT_W, bin count, valid the cycle after rd_en.
REQ-016 SHALL have port rd_valid, output, 1, qualifies rd_data.
REQ-017 SHALL have port total, output, CNT_W, completed groups counted.
REQ-018 SHALL have port sat, output, 1, sticky flag: a counter saturated.

Function
REQ-019 SHALL drive in_ready = !clear; no other backpressure.
REQ-020 SHALL, stage A, register the max (mode 0) or min (mode 1) of the LANES samples of each accepted beat, one cycle after acceptance.
REQ-021 SHALL, stage B, fold stage-A results into a group accumulator, with a beat counter 0..T/LANES-1 that wraps on the final beat.
REQ-022 SHALL latch mode at the first beat of each group; mode changes mid-group take effect at the next group.
REQ-023 SHALL, on the final beat of a group, register the group result one cycle after stage A, then reload the accumulator from the next group's first beat with no bubble.
REQ-024 SHALL, stage C, increment bin result[W-1 -: BIN_BITS] and total on the cycle after the group result; latency is 3 cycles from final-beat acceptance to updated counters.
REQ-025 SHALL, for gaps (in_valid low), hold all partial state; beats need not be contiguous.
REQ-026 SHALL saturate each bin counter and total at 2^CNT_W-1 and set sat at that edge; sat clears only on clear or rst.
REQ-027 SHALL register rd_data from the bin array; a same-edge update of the read bin returns the pre-update value.
REQ-028 SHALL, on clear, zero all bins, total, sat, beat counter and accumulator, and discard in-flight stage A/B/C contents at that edge; a beat presented with clear is dropped.
REQ-029 SHALL drive rd_valid = 0 and rd_data = 0 the cycle after a clear.
REQ-030 SHALL compare samples as unsigned; equal values may select either, with identical result.

Reset
REQ-031 SHALL on rst set all bins, total, rd_data, accumulator, beat counter to 0, sat, rd_valid and pipeline valids to 0, latched mode to 0.
REQ-032 SHALL have rst asserted mid-group discard the partial group; the first beat after release starts a new group.

Structure
REQ-033 SHALL place mode encoding (MODE_MAX/MODE_MIN) and parameter defaults in shared package maxt_pkg.
REQ-034 SHALL implement the combinational LANES-input max/min tree as sub-module maxt_reduce (params W, LANES), used by stage A.
REQ-035 SHALL reject illegal parameter combinations (T % LANES != 0, non-power-of-2) at elaboration.

Verification (defaults unless noted)
REQ-036 SHALL cover: mode 0, 4 beats all 0 except one 0xF800_0000 -> 3 cycles after 4th beat bin31 = 1, total = 1.
REQ-037 SHALL cover: mode 1, 4 beats all 0x1000_0000 except one 0x0800_0001 -> bin1 = 1, total = 1, bin2 = 0.
REQ-038 SHALL cover: 8 beats with in_valid low 1-3 cycles between beats -> total = 2, correct bins, same as gapless run.
REQ-039 SHALL cover: clear after 2 beats, then 4 beats max 0x0000_0001 -> bin0 = 1, total = 1, earlier beats absent.
REQ-040 SHALL cover: CNT_W = 4, 16 groups all mapping to bin0 -> bin0 = 15, total = 15, sat = 1.
REQ-041 SHALL cover: rst pulse mid-group, then 4 beats max 0xF800_0000 -> only bin31 = 1, total = 1.
